// File: rtl/kalman_update.sv
// -----------------------------------------------------------------------------
// kalman_update
//   Scalar Kalman measurement-update stage.
//     K     = p_pred / (p_pred + r_noise)        (unsigned Q1.FRAC, 0..2^FRAC)
//     x_upd = x_pred + ((K * (z - x_pred)) >>> FRAC)
//     p_upd = p_pred - ((K * p_pred) >> FRAC)
//   The gain comes from a bit-serial restoring divider (FRAC+1 cycles). One
//   transaction is in flight at a time; a new one is accepted only in IDLE.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready input handshake; operands sampled on accept
//   x_pred, z           signed state prediction and measurement
//   p_pred, r_noise     unsigned predicted covariance and measurement noise
//   out_valid/out_ready output handshake; results held until taken
//   x_upd, p_upd        updated state (signed) and covariance (unsigned)
//   k_gain              gain used for this update, Q1.FRAC
// -----------------------------------------------------------------------------
module kalman_update #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_pred,
  input  logic [W-1:0]  p_pred,
  input  logic [W-1:0]  z,
  input  logic [W-1:0]  r_noise,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  x_upd,
  output logic [W-1:0]  p_upd,
  output logic [FRAC:0] k_gain
);

  localparam int BW = $clog2(FRAC + 1);  // divider bit index width
  localparam int PW = W + FRAC + 2;      // signed gain * innovation width

  typedef enum logic [2:0] {IDLE, SUM, DIV, MUL, OUT} state_t;

  state_t state;

  // Latched operands
  logic [W-1:0] x_q, p_q, z_q, r_q;

  // Working registers
  logic [W:0]        s;      // p + r, cannot overflow in W+1 bits
  logic signed [W:0] innov;  // z - x, cannot overflow in W+1 bits
  logic [W+1:0]      rem;    // partial remainder, one spare bit for the shift
  logic [FRAC:0]     quot;   // gain being built MSB first
  logic [BW-1:0]     bidx;   // quotient bit being decided

  // Combinational datapath
  logic [W:0]          sum_next;
  logic signed [W:0]   innov_next;
  logic                rem_ge;
  logic [W+1:0]        rem_diff;
  logic [W+1:0]        rem_next;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] innov_ext;
  logic signed [PW-1:0] prod_x;
  logic [W+FRAC:0]     prod_p;
  logic [W-1:0]        x_next;
  logic [W-1:0]        p_next;

  // NOTE: every always_comb output is assigned on every path (here
  // unconditionally), so no latch can be inferred.
  always_comb begin
    sum_next   = {1'b0, p_q} + {1'b0, r_q};
    innov_next = $signed({z_q[W-1], z_q}) - $signed({x_q[W-1], x_q});

    // Restoring step: subtract when it fits, then shift for the next bit.
    // The remainder is always below s after this step, so the top bit is
    // zero and the shift loses nothing.
    rem_ge   = rem >= {1'b0, s};
    rem_diff = rem_ge ? (rem - {1'b0, s}) : rem;
    rem_next = rem_diff << 1;

    // K is non-negative; zero-extend it before the signed multiply so the
    // product keeps the sign of the innovation.
    k_ext     = $signed({{(PW-FRAC-1){1'b0}}, quot});
    innov_ext = {{(PW-W-1){innov[W]}}, innov};
    prod_x    = k_ext * innov_ext;
    // The correction always lands between x_pred and z, so wrapping to W
    // bits gives the exact result.
    x_next    = x_q + W'(prod_x >>> FRAC);

    prod_p = {{W{1'b0}}, quot} * {{(FRAC+1){1'b0}}, p_q};
    p_next = p_q - W'(prod_p >> FRAC);
  end

  // Accept only in IDLE and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  // NOTE: every register, including the datapath working set, is cleared by
  // the async reset so an abandoned transaction leaves no stale state behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      p_q       <= '0;
      z_q       <= '0;
      r_q       <= '0;
      s         <= '0;
      innov     <= '0;
      rem       <= '0;
      quot      <= '0;
      bidx      <= '0;
      out_valid <= 1'b0;
      x_upd     <= '0;
      p_upd     <= '0;
      k_gain    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= x_pred;
            p_q   <= p_pred;
            z_q   <= z;
            r_q   <= r_noise;
            state <= SUM;
          end
        end

        SUM: begin
          s     <= sum_next;
          innov <= innov_next;
          rem   <= {2'b00, p_q};
          quot  <= '0;
          bidx  <= BW'(FRAC);
          // p = r = 0: no meaningful gain, skip the divider with K = 0.
          state <= (sum_next == '0) ? MUL : DIV;
        end

        DIV: begin
          rem <= rem_next;
          if (rem_ge) quot[bidx] <= 1'b1;
          if (bidx == '0) state <= MUL;
          else            bidx  <= bidx - BW'(1);
        end

        MUL: begin
          x_upd     <= x_next;
          p_upd     <= p_next;
          k_gain    <= quot;
          out_valid <= 1'b1;
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_update.sv
// -----------------------------------------------------------------------------
// tb_kalman_update
//   Scoreboard bench for kalman_update. Expected results are pushed when a
//   transaction is accepted and compared when the DUT presents its output.
//   Inputs change 1 time unit after a rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_kalman_update;

  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam int LAT  = FRAC + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x_pred, p_pred, z, r_noise;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x_upd, p_upd;
  logic [FRAC:0] k_gain;

  kalman_update #(.W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_pred    (x_pred),
    .p_pred    (p_pred),
    .z         (z),
    .r_noise   (r_noise),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_upd     (x_upd),
    .p_upd     (p_upd),
    .k_gain    (k_gain)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  p;
    logic [FRAC:0] k;
    int            acc;  // number of the accepting rising edge
    int            lat;  // expected edges from accept to out_valid
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers (direct division, not bit-serial).
  function automatic void model(input logic signed [W-1:0] x, input logic [W-1:0] p,
                                input logic signed [W-1:0] zz, input logic [W-1:0] r,
                                output logic [W-1:0] ex, output logic [W-1:0] ep,
                                output logic [FRAC:0] ek);
    longint ps, rs, s, k, innov, xu, pu;
    ps    = longint'({32'h0, p});
    rs    = longint'({32'h0, r});
    s     = ps + rs;
    k     = (s == 0) ? 0 : ((ps << FRAC) / s);
    innov = longint'(zz) - longint'(x);
    xu    = longint'(x) + ((k * innov) >>> FRAC);
    pu    = ps - ((k * ps) >> FRAC);
    ex    = xu[W-1:0];
    ep    = pu[W-1:0];
    ek    = k[FRAC:0];
  endfunction

  // Present operands and wait (bounded) for acceptance; push the expectation
  // at the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] p,
                      input logic [W-1:0] zz, input logic [W-1:0] r,
                      input logic [W-1:0] ex, input logic [W-1:0] ep,
                      input logic [FRAC:0] ek, input int lat);
    exp_t e;
    @(posedge clk); #1;
    x_pred = x; p_pred = p; z = zz; r_noise = r; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.x = ex; e.p = ep; e.k = ek; e.acc = cyc + 1; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] x, input logic [W-1:0] p,
                            input logic [W-1:0] zz, input logic [W-1:0] r);
    logic [W-1:0]  ex, ep;
    logic [FRAC:0] ek;
    model(x, p, zz, r, ex, ep, ek);
    send(x, p, zz, r, ex, ep, ek, (p == 0 && r == 0) ? 2 : LAT);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Output monitor: latency on the rising out_valid, values on every valid
  // cycle (so held outputs must stay stable), pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          if (!prev_valid) check("spurious_out", 1, 0);
        end else begin
          if (!prev_valid) check("latency", cyc - sb[0].acc, sb[0].lat);
          check("x_upd",  x_upd,  sb[0].x);
          check("p_upd",  p_upd,  sb[0].p);
          check("k_gain", k_gain, sb[0].k);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x_pred = '0; p_pred = '0; z = '0; r_noise = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_upd",     x_upd,     0);
    check("rst_p_upd",     p_upd,     0);
    check("rst_k_gain",    k_gain,    0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // Directed cases with hand-derived expectations
    send(32'd1000, 32'd100, 32'd2000, 32'd100, 32'd1500, 32'd50, 17'd32768, LAT);
    send(32'd10,   32'd1,   -32'sd10, 32'd3,   32'd5,    32'd1,  17'd16384, LAT);
    send(32'd0,    32'd1,   32'd3,    32'd2,   32'd0,    32'd1,  17'd21845, LAT);
    send(-32'sd7,  32'd300, 32'd42,   32'd0,   32'd42,   32'd0,  17'd65536, LAT);
    send(32'd123,  32'd0,   -32'sd5,  32'd0,   32'd123,  32'd0,  17'd0,     2);
    drain();

    // Random operands, including full-range values and r = 0
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] rx, rp, rz, rr;
      rx = $urandom; rp = $urandom; rz = $urandom;
      rr = (i % 4 == 3) ? '0 : $urandom;
      if (i % 2 == 0) rp = rp >> $urandom_range(0, 24);
      send_model(rx, rp, rz, rr);
    end
    send_model(32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 32'hffff_ffff);
    drain();

    // Backpressure: result held, second operand set waits for the handshake
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'd1000, 32'd100, 32'd2000, 32'd100, 32'd1500, 32'd50, 17'd32768, LAT);
    @(posedge clk); #1;
    x_pred = -32'sd400; p_pred = 32'd900; z = 32'd600; r_noise = 32'd100;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_valid_seen", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send_model(-32'sd400, 32'd900, 32'd600, 32'd100);
    drain();

    // Reset in the middle of the divider
    send_model(32'd5000, 32'd700, -32'sd3000, 32'd50);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_release_in_ready", in_ready,  1);
    check("midrst_out_valid_after",  out_valid, 0);
    check("midrst_k_gain_cleared",   k_gain,    0);
    send_model(32'd5000, 32'd700, -32'sd3000, 32'd50);
    drain();
    repeat (3) @(negedge clk);
    check("final_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
